// File: rtl/uart_pkg.sv
// Shared definitions for the 5x-oversampling UART receiver.
// Holds the frame geometry, the sampling-phase window used for majority
// voting, and the receiver FSM state encoding.
package uart_pkg;

  localparam int OVERSAMPLE = 5;  // uart_clk ticks per bit period
  localparam int DATA_BITS  = 8;  // data bits per frame, LSB first

  // Phase counter values (3 bits cover 0..OVERSAMPLE-1).
  localparam logic [2:0] VOTE_LO    = 3'd1;                 // first voting sample
  localparam logic [2:0] VOTE_HI    = 3'd3;                 // last voting sample
  localparam logic [2:0] PHASE_EVAL = 3'(OVERSAMPLE - 1);   // bit decision phase

  localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_bit_sampler.sv
// Per-bit phase counter and 3-of-5 majority voter.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   tick       one-clk strobe on each uart_clk rising edge
//   sdi        synchronised serial input
//   start      load phase=1 and clear votes (start edge seen in IDLE)
//   active     FSM is inside a frame (START/DATA/STOP)
//   early      decide at the last voting phase instead of the eval phase
//              (used for the stop bit so the FSM can resync early)
//   bit_done   one-clk pulse: bit decision available this clk
//   bit_val    majority value of the centre samples, valid with bit_done
module uart_bit_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sdi,
  input  logic start,
  input  logic active,
  input  logic early,
  output logic bit_done,
  output logic bit_val
);

  logic [2:0] phase;
  logic [1:0] ones;
  logic       in_window;
  logic [2:0] votes;

  always_comb begin
    in_window = (phase >= VOTE_LO) && (phase <= VOTE_HI);
    // Include the current sample so the early (stop-bit) decision taken on
    // the last voting tick already sees all three centre samples.
    votes     = {1'b0, ones} + {2'b00, in_window & sdi};
    bit_val   = (votes >= 3'd2);
    bit_done  = tick && active &&
                (early ? (phase == VOTE_HI) : (phase == PHASE_EVAL));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      ones  <= '0;
    end else if (start) begin
      phase <= 3'd1;
      ones  <= '0;
    end else if (!active) begin
      phase <= '0;
      ones  <= '0;
    end else if (tick) begin
      if (bit_done) begin
        phase <= '0;
        ones  <= '0;
      end else begin
        phase <= phase + 3'd1;
        if (in_window && sdi) ones <= ones + 2'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_os5.sv
// 8N1 UART receiver clocked by the system clock, sampling on the rising
// edges of the prescaler's 5x-baud uart_clk. Received bytes are offered on
// a valid/ready holding register.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   uart_clk   5x baud square wave, synchronous to clk
//   rx         asynchronous serial input, idle high
//   rx_data    received byte, stable while rx_valid=1
//   rx_valid   byte available
//   rx_ready   consumer accepts byte on rx_valid && rx_ready
//   frame_err  one-clk pulse when the stop bit is sampled low
//   overrun    sticky flag: byte completed while holding register full
//   busy       FSM outside IDLE
module uart_rx_os5
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  logic                 rx_meta;
  logic                 sdi;
  logic                 uart_clk_q;
  logic                 tick;

  rx_state_e            state, state_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;

  logic                 start_det;
  logic                 bit_done;
  logic                 bit_val;
  logic                 stop_ok;
  logic                 stop_bad;
  logic                 accept;
  logic                 load;

  // Two-flop synchroniser; resets to the idle line level so a reset never
  // looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      sdi        <= 1'b1;
      uart_clk_q <= 1'b0;
    end else begin
      rx_meta    <= rx;
      sdi        <= rx_meta;
      uart_clk_q <= uart_clk;
    end
  end

  assign tick      = uart_clk & ~uart_clk_q;
  assign start_det = (state == IDLE) && tick && !sdi;

  uart_bit_sampler u_sampler (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .sdi      (sdi),
    .start    (start_det),
    .active   (state != IDLE),
    .early    (state == STOP),
    .bit_done (bit_done),
    .bit_val  (bit_val)
  );

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_det) state_nxt = START;
      end
      START: begin
        if (bit_done) begin
          if (bit_val) begin
            state_nxt = IDLE;  // glitch, not a real start bit
          end else begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_nxt = {bit_val, shift[DATA_BITS-1:1]};
          if (bit_idx == LAST_BIT_IDX) state_nxt = STOP;
          else                         bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_nxt = IDLE;
          stop_ok   = bit_val;
          stop_bad  = !bit_val;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  // Holding register: a new byte may load on the same clk the old one is
  // accepted, keeping rx_valid high without a bubble.
  assign accept = rx_valid && rx_ready;
  assign load   = stop_ok && (!rx_valid || rx_ready);

  // NOTE: the holding register is reset along with the control flops because
  // rx_data is a visible output with a defined reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (load) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
      if (stop_ok && rx_valid && !rx_ready) overrun <= 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os5.sv
// Randomised scoreboard bench for uart_rx_os5. A serial driver builds 8N1
// frames from bytes; a reference model decides what the consumer should
// receive and pushes it into a queue, and a monitor pops and compares on
// every accepted byte.
module tb_uart_rx_os5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_clk = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_os5 dut (
    .clk       (clk),
    .rst       (rst),
    .uart_clk  (uart_clk),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // uart_clk generator: half period in clk cycles, can be frozen.
  int uclk_half = 4;
  bit uclk_en   = 1'b1;
  initial forever begin
    repeat (uclk_half) @(posedge clk);
    #1;
    if (uclk_en) uart_clk = ~uart_clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] exp_q[$];
  bit         hold_full   = 1'b0;
  bit         exp_overrun = 1'b0;
  int         fe_expected = 0;
  int         fe_seen     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every accepted byte against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_seen++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected none at %0t", rx_data, $time);
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    hold_full   = 1'b0;
    exp_overrun = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_rx_data",   {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid",  {31'd0, rx_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun",   {31'd0, overrun}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one frame starting right after a uart_clk falling edge. Each bit
  // lasts five uart_clk periods; glitch_bit/glitch_period invert a single
  // period, abort_bit triggers a reset partway through that bit.
  task automatic send_frame(input logic [7:0] data, input bit stop_val,
                            input int glitch_bit, input int glitch_period,
                            input int abort_bit, input int gap);
    logic [9:0] bits;
    bits = {stop_val, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      if (b == 9) begin
        // Expectation is registered before the stop-bit decision happens.
        if (stop_val) begin
          if (hold_full && !rx_ready) exp_overrun = 1'b1;
          else begin
            exp_q.push_back(data);
            hold_full = !rx_ready;
          end
        end else begin
          fe_expected++;
        end
      end
      for (int p = 0; p < 5; p++) begin
        if (b == abort_bit && p == 2) begin
          rx = 1'b1;
          pulse_reset();
          return;
        end
        rx = (b == glitch_bit && p == glitch_period) ? ~bits[b] : bits[b];
        @(negedge uart_clk);
      end
    end
    rx = 1'b1;
    repeat (gap) @(negedge uart_clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d bytes outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic set_ready(input logic val);
    @(posedge clk);
    #1 rx_ready = val;
    if (val) hold_full = 1'b0;
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got no completion, expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    bit         sv;
    int         gb, gp;

    // Reset state.
    repeat (3) @(posedge clk);
    pulse_reset();

    // 0xA5 at the real 12 MHz / 48 kHz ratio (250 clk per uart_clk period).
    uclk_half = 125;
    @(negedge uart_clk);
    send_frame(8'hA5, 1'b1, -1, 0, -1, 2);
    @(negedge clk);
    check("a5_valid",   {31'd0, rx_valid}, 32'd1);
    check("a5_data",    {24'd0, rx_data}, 32'hA5);
    check("a5_busy",    {31'd0, busy}, 32'd0);
    check("a5_overrun", {31'd0, overrun}, 32'd0);
    check("a5_ferr",    32'(fe_seen), 32'(fe_expected));
    set_ready(1'b1);
    drain("a5");
    uclk_half = 4;

    // One-tick low glitch on an idle line.
    @(negedge uart_clk);
    rx = 1'b0;
    @(negedge uart_clk);
    rx = 1'b1;
    @(negedge clk);
    check("glitch_busy_start", {31'd0, busy}, 32'd1);
    repeat (3) @(posedge uart_clk);
    @(negedge clk);
    check("glitch_busy_tick4", {31'd0, busy}, 32'd1);
    @(posedge uart_clk);
    repeat (2) @(negedge clk);
    check("glitch_busy_end", {31'd0, busy}, 32'd0);
    check("glitch_valid",    {31'd0, rx_valid}, 32'd0);

    // Stop bit low, then a good frame.
    @(negedge uart_clk);
    send_frame(8'h3C, 1'b0, -1, 0, -1, 10);
    check("ferr_pulses", 32'(fe_seen), 32'(fe_expected));
    check("ferr_valid",  {31'd0, rx_valid}, 32'd0);
    send_frame(8'h55, 1'b1, -1, 0, -1, 2);
    drain("f55");

    // Back-to-back with consumer ready.
    send_frame(8'h00, 1'b1, -1, 0, -1, 0);
    send_frame(8'hFF, 1'b1, -1, 0, -1, 2);
    drain("b2b");
    check("b2b_overrun", {31'd0, overrun}, 32'd0);

    // Overrun with consumer stalled.
    set_ready(1'b0);
    @(negedge uart_clk);
    send_frame(8'h11, 1'b1, -1, 0, -1, 0);
    send_frame(8'h22, 1'b1, -1, 0, -1, 2);
    @(negedge clk);
    check("ovr_data",    {24'd0, rx_data}, 32'h11);
    check("ovr_valid",   {31'd0, rx_valid}, 32'd1);
    check("ovr_overrun", {31'd0, overrun}, {31'd0, exp_overrun});
    set_ready(1'b1);
    drain("ovr");
    repeat (2) @(negedge clk);
    check("ovr_valid_clr",  {31'd0, rx_valid}, 32'd0);
    check("ovr_sticky",     {31'd0, overrun}, {31'd0, exp_overrun});

    // uart_clk frozen mid-frame: FSM must hold, then finish normally.
    @(negedge uart_clk);
    fork
      send_frame(8'h5A, 1'b1, -1, 0, -1, 2);
      begin
        repeat (20) @(posedge uart_clk);
        uclk_en = 1'b0;
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("freeze_busy",  {31'd0, busy}, 32'd1);
        check("freeze_valid", {31'd0, rx_valid}, 32'd0);
        uclk_en = 1'b1;
      end
    join
    drain("freeze");

    // Reset during data bit 4 of 0xC3, then 0x81.
    @(negedge uart_clk);
    send_frame(8'hC3, 1'b1, -1, 0, 5, 0);
    repeat (2) @(negedge uart_clk);
    send_frame(8'h81, 1'b1, -1, 0, -1, 2);
    drain("f81");

    // Randomised frames with occasional single-sample glitches and bad stops.
    for (int n = 0; n < 30; n++) begin
      d  = 8'($urandom);
      sv = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 1) == 1) begin
        gb = $urandom_range(1, 8);
        gp = $urandom_range(1, 3);
      end else begin
        gb = -1;
        gp = 0;
      end
      send_frame(d, sv, gb, gp, -1, sv ? $urandom_range(0, 3) : 10);
    end
    drain("random");
    check("final_ferr",    32'(fe_seen), 32'(fe_expected));
    check("final_overrun", {31'd0, overrun}, {31'd0, exp_overrun});
    check("final_busy",    {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_os5.md
Name: uart_rx_os5

Overview:
Serial receiver that sits directly downstream of the clock prescaler. It consumes the prescaler's 5x-baud `uart_clk` square wave as a sample strobe, together with the raw `rx` pin. It recovers 8N1 bytes using 3-of-5 majority voting per bit. Each received byte is presented on a valid/ready holding register for the command decoder that drives the APU registers.

Parameters:
OVERSAMPLE, 5, uart_clk ticks per bit period; fixed at 5; phase counter is 3 bits
DATA_BITS, 8, data bits per frame, LSB first, no parity, 1 stop bit

Ports:
clk  input  1  system oscillator clock; the block's only clock
rst  input  1  reset, synchronous, active-high
uart_clk  input  1  5x baud square wave from prescaler, already synchronous to clk
rx  input  1  asynchronous serial input, idle high
rx_data  output  8  received byte; held stable while rx_valid=1
rx_valid  output  1  byte available
rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready on a clk edge
frame_err  output  1  one-clk pulse: stop bit sampled low
overrun  output  1  sticky: byte completed while holding register full; cleared only by rst
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE, phase=0, bit_idx=0, shift=0. Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0. Sync flops reset to 1 (idle line). A reset mid-frame abandons the frame with no output.
- Input sync: rx passes through 2 flops to give sdi. Latency is 2 clk.
- Tick generation: uart_clk_q is a 1-flop delay of uart_clk. tick = uart_clk & ~uart_clk_q, a one-clk pulse on each rising edge. All FSM activity advances only on tick.
- IDLE, on tick:
  - sdi=0: go to START, phase=1, clear vote counter.
  - Otherwise remain in IDLE.
- Phase handling, all bit states:
  - On each tick, phase increments.
  - At phases 1, 2 and 3, sdi is added to a 2-bit vote count of ones.
  - bit value = (ones >= 2), evaluated at the tick where phase=4 in START and DATA.
- START, at phase=4 tick:
  - bit=1: false start (glitch); return to IDLE, no output.
  - bit=0: go to DATA, phase=0, bit_idx=0.
- DATA, at phase=4 tick:
  - shift = {bit, shift[7:1]} (LSB first).
  - bit_idx=7: go to STOP, phase=0.
  - Otherwise bit_idx++ and phase=0.
- STOP: the decision is taken at the phase=3 tick, one tick early so the FSM can resync on the next start edge. Transition to IDLE on the same tick.
  - Stop bit=1 and rx_valid=0 (or rx_valid && rx_ready on this clk): rx_data<=shift, rx_valid<=1.
  - Stop bit=1 and rx_valid=1 and !rx_ready: new byte dropped, overrun<=1, rx_data unchanged.
  - Stop bit=0: frame_err pulses for 1 clk and the byte is discarded; overrun is not affected.
- Handshake:
  - rx_valid clears on the clk where rx_valid && rx_ready.
  - If load and accept coincide on the same clk, the new byte loads and rx_valid stays 1.
- Latency: rx_valid rises 1 clk after the stop-bit phase=3 tick.
- Voting tolerance:
  - One glitch sample per bit is tolerated.
  - A start pulse shorter than 2 of the 3 centre samples is rejected.
- With uart_clk held constant there are no ticks, and the FSM state is frozen.

Decomposition:
- Shared package uart_pkg:
  - OVERSAMPLE=5
  - DATA_BITS=8
  - state encoding IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3
  - VOTE_LO=1, VOTE_HI=3 (sampling phase window)
- One natural sub-module: uart_bit_sampler. It contains the phase counter, the vote counter and the bit output, and exposes bit_done and bit_val to the FSM.
- The synchronizer, tick edge-detect and holding register stay in the top module.

Test Plan:
- Send 0xA5 at 9600 baud, with uart_clk from the prescaler at 48 kHz and clk=12 MHz -> rx_valid=1 with rx_data=0xA5. frame_err=0, overrun=0, busy=0 after completion.
- Drive a 1-tick-wide (~20.8 us) low glitch on an idle line -> FSM returns to IDLE after 4 ticks; rx_valid stays 0.
- Send 0x3C with the stop bit forced low -> exactly one 1-clk frame_err pulse; rx_valid stays 0. A following frame 0x55 is received correctly.
- Send 0x00 then 0xFF back-to-back with rx_ready=1 -> two accepts, rx_data=0x00 then 0xFF; no overrun.
- Send 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11 held, overrun=1 after the second stop bit. Then assert rx_ready -> rx_valid=0 and overrun stays 1.
- Assert rst during data bit 4 of 0xC3 -> all outputs 0 on the next clk, busy=0. A frame 0x81 sent afterwards is received correctly.
